vga_frame_scanner: RTL and testbench



---
 rtl/vga_frame_scanner_if.sv | 11 +
 rtl/vga_frame_scanner.sv | 81 ++++++++
 tb/tb_vga_frame_scanner.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vga_frame_scanner_if.sv
// vga_frame_scanner_if: raster position, compositor address/hit and sprite-ROM bus
interface vga_frame_scanner_if;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [16:0] pixel_addr;
  logic notBlank;
  logic [16:0] rom_addr;
  logic [11:0] rom_data;
  modport master (output h_cnt, v_cnt, rom_addr, input pixel_addr, notBlank, rom_data);
  modport slave (input h_cnt, v_cnt, rom_addr, output pixel_addr, notBlank, rom_data);
endinterface

// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: raster timing, sprite-ROM read and latency-aligned VGA output
module vga_frame_scanner #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_VIS = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int ROM_LAT = 1,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input logic clk,
  input logic rst,
  vga_frame_scanner_if.master bus,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic hsync,
  output logic vsync,
  output logic frame_tick
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int D = 1 + ROM_LAT;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div;
  logic pix_en, h_end, v_end, vis0, hs0, vs0;
  logic [D-1:0] vis_p, hs_p, vs_p, nb_p;
  assign pix_en = div == DW'(CLK_DIV - 1);
  assign h_end = bus.h_cnt == 10'(H_TOT - 1);
  assign v_end = bus.v_cnt == 10'(V_TOT - 1);
  assign vis0 = (bus.h_cnt < 10'(H_VIS)) && (bus.v_cnt < 10'(V_VIS));
  assign hs0 = !((bus.h_cnt >= 10'(H_VIS + H_FP)) && (bus.h_cnt < 10'(H_VIS + H_FP + H_SYNC)));
  assign vs0 = !((bus.v_cnt >= 10'(V_VIS + V_FP)) && (bus.v_cnt < 10'(V_VIS + V_FP + V_SYNC)));
  // pixel-rate divider producing a one-clk pix_en
  always_ff @(posedge clk)
    if (rst) div <= '0;
    else div <= pix_en ? '0 : div + DW'(1);
  // raster counters; v advances on the h wrap, both wrap together at frame end
  always_ff @(posedge clk)
    if (rst) begin
      bus.h_cnt <= '0;
      bus.v_cnt <= '0;
    end else if (pix_en) begin
      bus.h_cnt <= h_end ? 10'd0 : bus.h_cnt + 10'd1;
      if (h_end) bus.v_cnt <= v_end ? 10'd0 : bus.v_cnt + 10'd1;
    end
  // ROM address capture and timing shift register matching the ROM latency
  always_ff @(posedge clk)
    if (rst) begin
      bus.rom_addr <= '0;
      vis_p <= '0;
      hs_p <= '1;
      vs_p <= '1;
      nb_p <= '0;
    end else if (pix_en) begin
      bus.rom_addr <= bus.pixel_addr;
      vis_p <= {vis_p[D-2:0], vis0};
      hs_p <= {hs_p[D-2:0], hs0};
      vs_p <= {vs_p[D-2:0], vs0};
      nb_p <= {nb_p[D-2:0], bus.notBlank};
    end
  // output register: colour mux and syncs from the same stage, plus frame tick
  always_ff @(posedge clk)
    if (rst) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      hsync <= 1'b1;
      vsync <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_en && h_end && (bus.v_cnt == 10'(V_VIS - 1));
      if (pix_en) begin
        {vga_r, vga_g, vga_b} <= vis_p[D-1] ? (nb_p[D-1] ? bus.rom_data : BG_COLOR) : 12'h000;
        hsync <= hs_p[D-1];
        vsync <= vs_p[D-1];
      end
    end
endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner: small-raster check of ROM_LAT=1 and ROM_LAT=3 builds
module tb_vga_frame_scanner;
  localparam int HV = 8, HF = 2, HS = 3, HB = 2, VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int H_TOT = HV + HF + HS + HB;
  localparam int V_TOT = VV + VF + VS + VB;
  localparam logic [11:0] BG = 12'h00F;
  logic clk = 0;
  logic rst = 1;
  bit [1:0] dcnt;
  bit tick_q, rst_q;
  logic [17:0] noise;
  logic [11:0] r1_rom;
  logic [11:0] r3_rom [0:2];
  logic [3:0] r1, g1, bl1, r3, g3, bl3;
  logic hs1, vs1, ft1, hs3, vs3, ft3;
  int checks = 0, errors = 0;
  int hm = 0, vm = 0;
  logic [13:0] hist [0:4];
  int hx [0:4], hy [0:4];
  vga_frame_scanner_if b1 ();
  vga_frame_scanner_if b3 ();
  vga_frame_scanner #(.CLK_DIV(4), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .ROM_LAT(1), .BG_COLOR(BG)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .vga_r(r1), .vga_g(g1), .vga_b(bl1),
    .hsync(hs1), .vsync(vs1), .frame_tick(ft1));
  vga_frame_scanner #(.CLK_DIV(4), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .ROM_LAT(3), .BG_COLOR(BG)) dut3 (
    .clk(clk), .rst(rst), .bus(b3), .vga_r(r3), .vga_g(g3), .vga_b(bl3),
    .hsync(hs3), .vsync(vs3), .frame_tick(ft3));
  always #5 clk = ~clk;
  // compositor model: true address only in the clk before a pixel tick, noise otherwise
  assign b1.pixel_addr = dcnt == 2'd3 ? {b1.v_cnt[7:0], b1.h_cnt[8:0]} : noise[16:0];
  assign b1.notBlank = dcnt == 2'd3 ? b1.h_cnt[1:0] != 2'd3 : noise[17];
  assign b3.pixel_addr = dcnt == 2'd3 ? {b3.v_cnt[7:0], b3.h_cnt[8:0]} : noise[16:0];
  assign b3.notBlank = dcnt == 2'd3 ? b3.h_cnt[1:0] != 2'd3 : noise[17];
  assign b1.rom_data = r1_rom;
  assign b3.rom_data = r3_rom[2];
  // pixel-rate model of the divider and the sprite ROMs (latency in pixel ticks)
  always @(posedge clk) begin
    dcnt <= rst ? 2'd0 : dcnt + 2'd1;
    tick_q <= !rst && dcnt == 2'd3;
    rst_q <= rst;
    noise <= 18'($urandom);
    if (!rst && dcnt == 2'd3) begin
      r1_rom <= b1.rom_addr[11:0];
      r3_rom[0] <= b3.rom_addr[11:0];
      r3_rom[1] <= r3_rom[0];
      r3_rom[2] <= r3_rom[1];
    end
  end
  task automatic ck(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (hm=%0d vm=%0d t=%0t)", tag, got, exp, hm, vm, $time);
    end
  endtask
  function automatic logic [13:0] expv(input int h, input int v);
    logic [11:0] rgb;
    logic vis, nb, hsn, vsn;
    vis = h < HV && v < VV;
    nb = (h % 4) != 3;
    rgb = vis ? (nb ? 12'(((v % 256) * 512 + h) % 4096) : BG) : 12'h000;
    hsn = !(h >= HV + HF && h < HV + HF + HS);
    vsn = !(v >= VV + VF && v < VV + VF + VS);
    return {rgb, hsn, vsn};
  endfunction
  task automatic cycle();
    bit ft;
    @(posedge clk);
    #1;
    ft = 0;
    if (rst_q) begin
      hm = 0;
      vm = 0;
      for (int i = 0; i < 5; i++) begin
        hist[i] = 14'h0003;
        hx[i] = -1;
        hy[i] = -1;
      end
    end else if (tick_q) begin
      ft = hm == H_TOT - 1 && vm == VV - 1;
      for (int i = 4; i > 0; i--) begin
        hist[i] = hist[i-1];
        hx[i] = hx[i-1];
        hy[i] = hy[i-1];
      end
      hist[0] = expv(hm, vm);
      hx[0] = hm;
      hy[0] = vm;
      if (hm == H_TOT - 1) begin
        hm = 0;
        vm = vm == V_TOT - 1 ? 0 : vm + 1;
      end else hm++;
    end
    ck("h_cnt1", b1.h_cnt, hm);
    ck("v_cnt1", b1.v_cnt, vm);
    ck("h_cnt3", b3.h_cnt, hm);
    ck("v_cnt3", b3.v_cnt, vm);
    ck("pins1", {r1, g1, bl1}, hist[2][13:2]);
    ck("hsync1", hs1, hist[2][1]);
    ck("vsync1", vs1, hist[2][0]);
    ck("ftick1", ft1, ft);
    ck("pins3", {r3, g3, bl3}, hist[4][13:2]);
    ck("hsync3", hs3, hist[4][1]);
    ck("vsync3", vs3, hist[4][0]);
    ck("ftick3", ft3, ft);
    if (tick_q && !rst_q) begin
      if (hx[2] == 5 && hy[2] == 3) ck("px53_lat1", {r1, g1, bl1}, 12'h605);
      if (hx[4] == 5 && hy[4] == 3) ck("px53_lat3", {r3, g3, bl3}, 12'h605);
      if (hx[2] == 3 && hy[2] == 0) ck("px30_bg", {r1, g1, bl1}, 12'h00F);
      if (hx[2] == 9 && hy[2] == 0) ck("px90_blank", {r1, g1, bl1}, 12'h000);
      if (hx[2] == 11 && hy[2] == 0) ck("px110_hs", hs1, 0);
      if (hx[4] == 2 && hy[4] == 5) ck("px25_vs3", vs3, 0);
    end
  endtask
  initial begin
    for (int i = 0; i < 5; i++) begin
      hist[i] = 14'h0003;
      hx[i] = -1;
      hy[i] = -1;
    end
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    repeat (2 * 4 * H_TOT * V_TOT + 20) cycle();
    for (int i = 0; i < 4 * H_TOT * V_TOT && !(hm == 12 && vm == 2); i++) cycle();
    if (!(hm == 12 && vm == 2)) ck("seek_mid_frame", 0, 1);
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    ck("rst_hsync1", hs1, 1);
    ck("rst_pins1", {r1, g1, bl1}, 12'h000);
    ck("rst_h1", b1.h_cnt, 0);
    repeat (4 * H_TOT * V_TOT + 40) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
